slice_field_reader: RTL and testbench

- Read-side counterpart to our partial-slice register writers: extracts a bit-field (lsb, len) from a source word and returns it through a valid/ready response.
- Snapshots the word on request accept, then extracts it bit-serially, one bit per cycle.
- Optionally sign-extends the result to the output width.
- Used in equivalence benches to read back slices written by partial-select writers.

---
 rtl/slice_pkg.sv | 20 ++
 rtl/slice_field_reader_if.sv | 29 ++
 rtl/slice_sign_ext.sv | 26 ++
 rtl/slice_field_reader.sv | 119 +++++++++++
 tb/tb_slice_field_reader.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/slice_pkg.sv
// Shared types, defaults and the request legality rule for the slice reader.
package slice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXTRACT = 2'd1,
        RESP    = 2'd2
    } state_e;

    localparam int WORD_W_DEF = 32;
    localparam int OUT_W_DEF  = 8;

    // sum is lsb+len taken at full width, so an overflowing field can never
    // alias back into range.
    function automatic logic req_legal(input int sum, input int len,
                                       input int word_w, input int out_w);
        return (len >= 1) && (len <= out_w) && (sum <= word_w);
    endfunction

endpackage

// File: rtl/slice_field_reader_if.sv
// Request/response bundle between a requester and the slice reader.
interface slice_field_reader_if
    import slice_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int IDX_W  = $clog2(WORD_W)
);
    logic [WORD_W-1:0] src_word;
    logic              req_valid;
    logic              req_ready;
    logic [IDX_W-1:0]  req_lsb;
    logic [IDX_W:0]    req_len;
    logic              req_signed;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [OUT_W-1:0]  rsp_data;
    logic              rsp_err;

    modport master (
        output src_word, req_valid, req_lsb, req_len, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  src_word, req_valid, req_lsb, req_len, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/slice_sign_ext.sv
// Pads an extracted field of len bits to OUT_W with its sign bit or zeros.
module slice_sign_ext
    import slice_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int LEN_W = 6
) (
    input  logic [OUT_W-1:0] res,
    input  logic [LEN_W-1:0] len,
    input  logic             sgn,
    output logic [OUT_W-1:0] data
);
    logic fill;

    // Fill bit is bit len-1 when signed; out-of-range len yields zero fill.
    always_comb begin
        fill = 1'b0;
        data = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (sgn && (LEN_W'(i + 1) == len)) fill = res[i];
        end
        for (int i = 0; i < OUT_W; i++) begin
            data[i] = (LEN_W'(i) < len) ? res[i] : fill;
        end
    end
endmodule

// File: rtl/slice_field_reader.sv
// Snapshots a word on request accept, extracts field (lsb,len) one bit per
// cycle, then holds the (optionally sign-extended) result until taken.
module slice_field_reader
    import slice_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int IDX_W  = $clog2(WORD_W)
) (
    input logic                clock_0,
    input logic                clock_2,
    slice_field_reader_if.slave bus
);
    localparam int LEN_W = IDX_W + 1;
    localparam int SUM_W = IDX_W + 2;
    localparam int K_W   = $clog2(OUT_W);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]  lsb_q, lsb_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              sgn_q, sgn_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic [OUT_W-1:0]  res_q, res_d;

    logic [SUM_W-1:0]  req_sum;
    logic              legal;
    logic [IDX_W-1:0]  rd_idx;
    logic [OUT_W-1:0]  ext_data;

    // Legality uses the unwrapped lsb+len so fields past the top are caught.
    always_comb begin
        req_sum = SUM_W'(bus.req_lsb) + SUM_W'(bus.req_len);
        legal   = req_legal(int'(req_sum), int'(bus.req_len), WORD_W, OUT_W);
        // Legal fields never run past the word, so lsb+k fits the index.
        rd_idx  = lsb_q + IDX_W'(k_q);
    end

    // Next-state and datapath updates for the accept/extract/respond cycle.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        lsb_d   = lsb_q;
        len_d   = len_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        k_d     = k_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    snap_d  = bus.src_word;
                    lsb_d   = bus.req_lsb;
                    len_d   = bus.req_len;
                    sgn_d   = bus.req_signed;
                    k_d     = '0;
                    res_d   = '0;
                    err_d   = !legal;
                    state_d = legal ? EXTRACT : RESP;
                end
            end
            EXTRACT: begin
                res_d[k_q[K_W-1:0]] = snap_q[rd_idx];
                k_d = k_q + LEN_W'(1);
                if (k_q == len_q - LEN_W'(1)) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    res_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset abandons any operation in flight.
    always_ff @(posedge clock_0 or posedge clock_2) begin
        if (clock_2) begin
            state_q <= IDLE;
            snap_q  <= '0;
            lsb_q   <= '0;
            len_q   <= '0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            lsb_q   <= lsb_d;
            len_q   <= len_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            k_q     <= k_d;
            res_q   <= res_d;
        end
    end

    slice_sign_ext #(
        .OUT_W (OUT_W),
        .LEN_W (LEN_W)
    ) u_ext (
        .res  (res_q),
        .len  (len_q),
        .sgn  (sgn_q),
        .data (ext_data)
    );

    // Outputs decode from state so reset clears them without a clock edge.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_err   = bus.rsp_valid && err_q;
        bus.rsp_data  = (bus.rsp_valid && !err_q) ? ext_data : '0;
    end
endmodule

// File: tb/tb_slice_field_reader.sv
// Directed bench for slice_field_reader (WORD_W=32, OUT_W=8).
module tb_slice_field_reader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;

    slice_field_reader_if #(.WORD_W(32), .OUT_W(8)) bus ();

    slice_field_reader #(.WORD_W(32), .OUT_W(8)) dut (
        .clock_0 (clk),
        .clock_2 (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one request and wait for the response; n = edges after accept.
    task automatic issue(input logic [31:0] src, input int lsb, input int len,
                         input logic sgn, output int n);
        logic [4:0] l5;
        logic [5:0] n6;
        l5 = lsb[4:0];
        n6 = len[5:0];
        @(negedge clk);
        bus.src_word   = src;
        bus.req_lsb    = l5;
        bus.req_len    = n6;
        bus.req_signed = sgn;
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic take(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_vld_clr"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] src, input int lsb,
                       input int len, input logic sgn, input logic [7:0] exp_d,
                       input logic exp_e, input int exp_n);
        int n;
        issue(src, lsb, len, sgn, n);
        chk({tag, "_lat"}, 32'(n), 32'(exp_n));
        chk({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_e));
        take(tag);
    endtask

    initial begin
        int n;
        bus.src_word   = '0;
        bus.req_valid  = 1'b0;
        bus.req_lsb    = '0;
        bus.req_len    = '0;
        bus.req_signed = 1'b0;
        bus.rsp_ready  = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Legal fields: response after len extraction edges.
        run("u4", 32'h0000_0F00, 8, 4, 1'b0, 8'h0F, 1'b0, 4);
        run("s4", 32'h0000_0A00, 8, 4, 1'b1, 8'hFA, 1'b0, 4);
        run("u4b", 32'h0000_0A00, 8, 4, 1'b0, 8'h0A, 1'b0, 4);

        // Illegal fields go straight to RESP at the accept edge.
        run("len0", 32'hFFFF_FFFF, 0, 0, 1'b0, 8'h00, 1'b1, 0);
        run("ovr", 32'hFFFF_FFFF, 30, 4, 1'b0, 8'h00, 1'b1, 0);
        run("len9", 32'hFFFF_FFFF, 0, 9, 1'b1, 8'h00, 1'b1, 0);
        run("ovr1", 32'hFFFF_FFFF, 25, 8, 1'b0, 8'h00, 1'b1, 0);

        // Snapshot isolation and response hold under back-pressure.
        @(negedge clk);
        bus.src_word  = 32'h0000_00C3;
        bus.req_lsb   = 5'd0;
        bus.req_len   = 6'd8;
        bus.req_signed = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.src_word  = 32'hFFFF_FFFF;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("hold_lat", 32'(n), 32'd8);
        for (int c = 0; c < 5; c++) begin
            chk("hold_data", 32'(bus.rsp_data), 32'h0000_00C3);
            chk("hold_rdy", 32'(bus.req_ready), 32'd0);
            chk("hold_vld", 32'(bus.rsp_valid), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        take("hold");
        chk("hold_data_clr", 32'(bus.rsp_data), 32'd0);
        chk("hold_err_clr", 32'(bus.rsp_err), 32'd0);

        // Asynchronous reset on EXTRACT cycle 2.
        @(negedge clk);
        bus.src_word  = 32'h0000_00FF;
        bus.req_lsb   = 5'd0;
        bus.req_len   = 6'd8;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(bus.req_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid_vld", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rdy", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run("post", 32'h0000_0003, 0, 2, 1'b0, 8'h03, 1'b0, 2);

        // Field reaching the top bit; full-width signed has no fill.
        run("top", 32'h8000_0000, 24, 8, 1'b1, 8'h80, 1'b0, 8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
